integral_image_rect_sum_reader: RTL and testbench
=================================================

INTEGRAL_IMAGE_RECT_SUM_READER -- requirements
Module: integral_image_rect_sum_reader

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, integral-value and sum width.
REQ-002 SHALL have parameter X_WIDTH, default 9, column address width.
REQ-003 SHALL have parameter Y_WIDTH, default 8, row address width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid input 1 and req_ready output 1, the rectangle-request handshake.
REQ-007 SHALL have ports req_x0, req_x1  input  X_WIDTH  inclusive left/right columns.
REQ-008 SHALL have ports req_y0, req_y1  input  Y_WIDTH  inclusive top/bottom rows.
REQ-009 SHALL have port re  output  1  cache read enable.
REQ-010 SHALL have ports raddrX output X_WIDTH and raddrY output Y_WIDTH, cache read address.
REQ-011 SHALL have port rdata  input  WORD_SIZE  cache data, valid exactly one cycle after re.
REQ-012 SHALL have ports sum_valid output 1 and sum_ready input 1, the result handshake.
REQ-013 SHALL have port sum  output  WORD_SIZE  rectangle sum.
REQ-014 SHALL have port err  output  1  invalid-rectangle flag, qualified by sum_valid.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, OUT; req_ready=1 only in IDLE.
REQ-016 SHALL capture req_* on req_valid&&req_ready (cycle T) and move to ISSUE.
REQ-017 SHALL compute sum = I(x1,y1) - I(x0-1,y1) - I(x1,y0-1) + I(x0-1,y0-1), modulo 2^WORD_SIZE.
REQ-018 SHALL issue reads in order D(x1,y1), B(x0-1,y1), C(x1,y0-1), A(x0-1,y0-1) on consecutive cycles from T+1, re=1 each cycle.
REQ-019 SHALL skip B and A when x0==0 and skip C and A when y0==0; read count N is 1, 2 or 4.
REQ-020 SHALL accumulate each rdata one cycle after its read (add D, A; subtract B, C); accumulator cleared at accept.
REQ-021 SHALL enter DRAIN after the last read and OUT after the last rdata is accumulated; sum_valid first high at T+N+2.
REQ-022 SHALL hold sum, err, sum_valid stable in OUT until sum_ready=1; leave to IDLE on that edge.
REQ-023 SHALL not accept a new request in the cycle sum is consumed; req_ready rises the following cycle.
REQ-024 SHALL drive re=0 outside ISSUE; raddrX/raddrY SHALL be don't-care when re=0 but never X in simulation.
REQ-025 SHALL ignore req_* changes while not in IDLE.

Reset
REQ-026 SHALL, on resetn=0 at a clock edge, enter IDLE and drive req_ready=0 during reset, re=0, sum_valid=0, sum=0, err=0, raddrX=0, raddrY=0.
REQ-027 SHALL abort any in-flight request on reset mid-operation; rdata arriving after reset SHALL be discarded; no sum_valid for the aborted request.
REQ-028 SHALL assert req_ready in the first cycle after resetn returns to 1.

Configuration
REQ-029 SHALL honour macro IIC_RECT_CHECK_EN.
REQ-030 With IIC_RECT_CHECK_EN defined: if x0>x1 or y0>y1 at accept, SHALL issue no reads and present sum=0, err=1, sum_valid high at T+2.
REQ-031 Without IIC_RECT_CHECK_EN: no check; err SHALL be tied 0; corners used as given with wrapping arithmetic.

Verification (cache model preloaded I(x,y)=(x+1)*(y+1), 1-cycle read latency)
REQ-032 Request (x0=2,y0=3,x1=5,y1=7) -> 4 reads at (5,7),(1,7),(5,2),(1,2); sum=20, err=0, sum_valid at T+6.
REQ-033 Request (0,0,3,2) -> single read (3,2); sum=12, sum_valid at T+3; (0,4,1,4) -> reads (1,4),(1,3); sum=2 at T+4.
REQ-034 Request (2,3,5,7) with sum_ready low 5 cycles after sum_valid -> sum=20 held, req_ready=0, re=0 throughout; IDLE one cycle after sum_ready=1.
REQ-035 With IIC_RECT_CHECK_EN, request (6,0,2,0) -> no re, sum=0, err=1 at T+2; without macro err stays 0.
REQ-036 resetn=0 at T+2 of request (2,3,5,7) -> re=0, sum_valid=0 next cycle; following request (0,0,0,0) returns sum=1 at T'+3.

Source files
------------

// File: rtl/integral_image_rect_sum_reader_if.sv
// rtl/integral_image_rect_sum_reader_if.sv - request, cache-read and result bundle for the rect-sum reader
interface integral_image_rect_sum_reader_if #(
  parameter int WORD_SIZE = 32,
  parameter int X_WIDTH   = 9,
  parameter int Y_WIDTH   = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [X_WIDTH-1:0]   req_x0;
  logic [X_WIDTH-1:0]   req_x1;
  logic [Y_WIDTH-1:0]   req_y0;
  logic [Y_WIDTH-1:0]   req_y1;
  logic                 re;
  logic [X_WIDTH-1:0]   raddrX;
  logic [Y_WIDTH-1:0]   raddrY;
  logic [WORD_SIZE-1:0] rdata;
  logic                 sum_valid;
  logic                 sum_ready;
  logic [WORD_SIZE-1:0] sum;
  logic                 err;

  // master is the reader itself; slave is the requester plus the cache
  modport master (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, rdata, sum_ready,
    output req_ready, re, raddrX, raddrY, sum_valid, sum, err
  );
  modport slave (
    output req_valid, req_x0, req_x1, req_y0, req_y1, rdata, sum_ready,
    input  req_ready, re, raddrX, raddrY, sum_valid, sum, err
  );
endinterface

// File: rtl/integral_image_rect_sum_reader.sv
// rtl/integral_image_rect_sum_reader.sv - four-corner integral-image rectangle sum; optional IIC_RECT_CHECK_EN corner-order check
module integral_image_rect_sum_reader #(
  parameter int WORD_SIZE = 32,
  parameter int X_WIDTH   = 9,
  parameter int Y_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  integral_image_rect_sum_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t               state, state_nxt;
  logic [X_WIDTH-1:0]   x0_q, x1_q, x0_m1;
  logic [Y_WIDTH-1:0]   y0_q, y1_q, y0_m1;
  logic [3:0]           pend, cur, pend_left;
  logic                 rd_valid, rd_sub;
  logic [WORD_SIZE-1:0] acc;
  logic                 accept, bad_rect;

  // pend bits: 0=D(x1,y1) 1=B(x0-1,y1) 2=C(x1,y0-1) 3=A(x0-1,y0-1); lowest set bit issues first
  assign cur       = pend & (~pend + 4'd1);
  assign pend_left = pend & ~cur;
  assign x0_m1     = x0_q - X_WIDTH'(1);
  assign y0_m1     = y0_q - Y_WIDTH'(1);
  assign accept    = bus.req_valid && bus.req_ready;

`ifdef IIC_RECT_CHECK_EN
  logic err_q;
  assign bad_rect = (bus.req_x0 > bus.req_x1) || (bus.req_y0 > bus.req_y1);
  assign bus.err  = err_q;
  always_ff @(posedge clk) begin
    if (!resetn)     err_q <= 1'b0;
    else if (accept) err_q <= bad_rect;
  end
`else
  assign bad_rect = 1'b0;
  assign bus.err  = 1'b0;
`endif

  assign bus.sum = acc;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_rect ? DRAIN : ISSUE;
      ISSUE:   if (pend_left == 4'd0) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (bus.sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && resetn;
    bus.re        = 1'b0;
    bus.raddrX    = '0;
    bus.raddrY    = '0;
    bus.sum_valid = (state == OUT);
    if (state == ISSUE) begin
      bus.re     = 1'b1;
      bus.raddrX = (cur[1] || cur[3]) ? x0_m1 : x1_q;
      bus.raddrY = (cur[2] || cur[3]) ? y0_m1 : y1_q;
    end
  end

  // rd_valid/rd_sub trail each read by one cycle to line up with rdata
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      pend     <= 4'd0;
      rd_valid <= 1'b0;
      rd_sub   <= 1'b0;
      acc      <= '0;
    end else begin
      rd_valid <= (state == ISSUE);
      rd_sub   <= cur[1] || cur[2];
      if (accept) begin
        x0_q <= bus.req_x0;
        x1_q <= bus.req_x1;
        y0_q <= bus.req_y0;
        y1_q <= bus.req_y1;
        pend <= bad_rect ? 4'd0 :
                {(bus.req_x0 != '0) && (bus.req_y0 != '0), bus.req_y0 != '0, bus.req_x0 != '0, 1'b1};
      end else if (state == ISSUE) begin
        pend <= pend_left;
      end
      if (rd_valid)    acc <= rd_sub ? acc - bus.rdata : acc + bus.rdata;
      else if (accept) acc <= '0;
    end
  end
endmodule

// File: tb/tb_integral_image_rect_sum_reader.sv
// tb/tb_integral_image_rect_sum_reader.sv - randomized self-checking bench for integral_image_rect_sum_reader
module tb_integral_image_rect_sum_reader;
  localparam int WS = 32;
  localparam int XW = 9;
  localparam int YW = 8;
`ifdef IIC_RECT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  integral_image_rect_sum_reader_if #(.WORD_SIZE(WS), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  integral_image_rect_sum_reader #(.WORD_SIZE(WS), .X_WIDTH(XW), .Y_WIDTH(YW)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int exp_rd[$];
  int got_rd[$];
  logic [WS-1:0] exp_sum;
  bit exp_err;

  function automatic logic [WS-1:0] img(input int x, input int y);
    return WS'((x + 1) * (y + 1));
  endfunction

  // cache: one-cycle latency, junk on idle cycles
  always @(posedge clk)
    bus.rdata <= bus.re ? img(int'(bus.raddrX), int'(bus.raddrY)) : WS'($urandom);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: the corner list and inclusion-exclusion sum straight from the rectangle definition
  task automatic model(input int x0, input int y0, input int x1, input int y1);
    exp_rd.delete();
    exp_sum = '0;
    exp_err = 1'b0;
    if (CHECK_EN && (x0 > x1 || y0 > y1)) begin
      exp_err = 1'b1;
      return;
    end
    exp_rd.push_back(x1 * 256 + y1);
    exp_sum = img(x1, y1);
    if (x0 != 0) begin
      exp_rd.push_back((x0 - 1) * 256 + y1);
      exp_sum = exp_sum - img(x0 - 1, y1);
    end
    if (y0 != 0) begin
      exp_rd.push_back(x1 * 256 + (y0 - 1));
      exp_sum = exp_sum - img(x1, y0 - 1);
    end
    if (x0 != 0 && y0 != 0) begin
      exp_rd.push_back((x0 - 1) * 256 + (y0 - 1));
      exp_sum = exp_sum + img(x0 - 1, y0 - 1);
    end
  endtask

  // called at posedge+1; returns at posedge+1 of the cycle after the accept edge
  task automatic send(input int x0, input int y0, input int x1, input int y1, output bit ok);
    ok = 1'b0;
    bus.req_x0 = XW'(x0);
    bus.req_y0 = YW'(y0);
    bus.req_x1 = XW'(x1);
    bus.req_y1 = YW'(y1);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_x0 = XW'($urandom);
    bus.req_y0 = YW'($urandom);
    bus.req_x1 = XW'($urandom);
    bus.req_y1 = YW'($urandom);
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic run_req(input int x0, input int y0, input int x1, input int y1, input int hold);
    bit ok;
    int lat;
    model(x0, y0, x1, y1);
    send(x0, y0, x1, y1, ok);
    if (!ok) return;
    got_rd.delete();
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.sum_valid) begin
        lat = c;
        break;
      end
      if (bus.re) got_rd.push_back(int'(bus.raddrX) * 256 + int'(bus.raddrY));
      @(posedge clk); #1;
    end
    check("latency", lat, exp_rd.size() + 2);
    check("n_reads", got_rd.size(), exp_rd.size());
    foreach (exp_rd[i])
      if (i < got_rd.size()) check($sformatf("read%0d_xy", i), got_rd[i], exp_rd[i]);
    if (lat == 0) return;
    check("sum", bus.sum, exp_sum);
    check("err", bus.err, exp_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.sum_valid, 1);
      check("hold_sum", bus.sum, exp_sum);
      check("hold_err", bus.err, exp_err);
      check("hold_req_ready", bus.req_ready, 0);
      check("hold_re", bus.re, 0);
    end
    bus.sum_ready = 1'b1;
    @(posedge clk); #1;
    bus.sum_ready = 1'b0;
    check("post_valid", bus.sum_valid, 0);
    check("post_req_ready", bus.req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int x0, x1, y0, y1;
    bus.req_valid = 1'b0;
    bus.sum_ready = 1'b0;
    bus.req_x0 = '0;
    bus.req_x1 = '0;
    bus.req_y0 = '0;
    bus.req_y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_re", bus.re, 0);
    check("rst_sum_valid", bus.sum_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_err", bus.err, 0);
    check("rst_raddr", {bus.raddrX, bus.raddrY}, 0);
    resetn = 1'b1;
    #1;
    check("rst_release_ready", bus.req_ready, 1);
    @(posedge clk); #1;

    run_req(2, 3, 5, 7, 0);
    run_req(0, 0, 3, 2, 0);
    run_req(0, 4, 1, 4, 0);
    run_req(2, 3, 5, 7, 5);
    run_req(6, 0, 2, 0, 1);
    run_req(1, 1, 511, 255, 2);
    run_req(511, 255, 511, 255, 0);

    // reset two cycles into a four-read request
    send(2, 3, 5, 7, ok);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("abort_re", bus.re, 0);
    check("abort_sum_valid", bus.sum_valid, 0);
    check("abort_req_ready", bus.req_ready, 0);
    resetn = 1'b1;
    #1;
    check("abort_release_ready", bus.req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_sum", bus.sum_valid, 0);
    end
    run_req(0, 0, 0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      x0 = $urandom_range(0, 511);
      x1 = $urandom_range(0, 511);
      y0 = $urandom_range(0, 255);
      y1 = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) x0 = 0;
      if ($urandom_range(0, 3) == 0) y0 = 0;
      run_req(x0, y0, x1, y1, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
